// File: rtl/easy_pio_gpio.sv
// easy_pio_gpio: Avalon-MM GPIO slave with an output register (atomic set/clear),
// a synchronised input with sticky rising-edge capture, and a maskable level irq.
// The timed-pulse output (PULSE register, address 6) exists only when
// EASY_PIO_PULSE_EN is defined; otherwise address 6 is reserved.
// Ports: clk, reset_n (sync, active-low), address[2:0], chipselect, write_n,
//   writedata[WIDTH-1:0], readdata[WIDTH-1:0] (zero wait),
//   in_port[WIDTH-1:0] (async), out_port[WIDTH-1:0], irq (active-high level).
// Register map: 0 DATA, 1 IN, 2 IRQ_MASK, 3 EDGE_CAP (W1C), 4 OUTSET,
//   5 OUTCLEAR, 6 PULSE (reads remaining count), 7 reserved.
module easy_pio_gpio #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int               PULSE_CYCLES = 50
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   logic             wr;
   logic             wr_data;
   logic             wr_mask;
   logic             wr_edge;
   logic             wr_set;
   logic             wr_clr;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_n;
   logic [WIDTH-1:0] in_meta;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_dly;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_cap_n;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] exp_clr;

   assign wr      = chipselect & ~write_n;
   assign wr_data = wr & (address == 3'd0);
   assign wr_mask = wr & (address == 3'd2);
   assign wr_edge = wr & (address == 3'd3);
   assign wr_set  = wr & (address == 3'd4);
   assign wr_clr  = wr & (address == 3'd5);

   // A fresh rising edge wins over a W1C of the same bit.
   assign rise       = in_sync & ~in_dly;
   assign w1c        = wr_edge ? writedata : '0;
   assign edge_cap_n = (edge_cap & ~w1c) | rise;

`ifdef EASY_PIO_PULSE_EN
   localparam int CW = $clog2(PULSE_CYCLES + 1);

   logic             wr_pulse;
   logic             expire;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic [WIDTH-1:0] pmask;
   logic [WIDTH-1:0] pmask_n;

   assign wr_pulse = wr & (address == 3'd6);
   // Counter value 1 means this edge ends the pulse.
   assign expire   = (cnt == CW'(1));
   assign exp_clr  = expire ? pmask : '0;

   // Expiry is resolved first; a PULSE write then ORs into what remains
   // and restarts the count for every pending pulse bit.
   always_comb begin
      pmask_n = pmask;
      cnt_n   = cnt;
      if (expire) begin
         pmask_n = '0;
         cnt_n   = '0;
      end else if (cnt != '0) begin
         cnt_n = cnt - CW'(1);
      end
      if (wr_pulse) begin
         pmask_n = pmask_n | writedata;
         cnt_n   = CW'(PULSE_CYCLES);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pmask <= '0;
         cnt   <= '0;
      end else begin
         pmask <= pmask_n;
         cnt   <= cnt_n;
      end
   end
`else
   assign exp_clr = '0;
`endif

   // CPU writes land on top of the expiry result; DATA overrides all.
   always_comb begin
      data_n = data_out & ~exp_clr;
      if (wr_set) begin
         data_n = data_n | writedata;
      end
      if (wr_clr) begin
         data_n = data_n & ~writedata;
      end
`ifdef EASY_PIO_PULSE_EN
      if (wr_pulse) begin
         data_n = data_n | writedata;
      end
`endif
      if (wr_data) begin
         data_n = writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out <= RESET_VALUE;
         in_meta  <= '0;
         in_sync  <= '0;
         in_dly   <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         irq      <= 1'b0;
      end else begin
         data_out <= data_n;
         in_meta  <= in_port;
         in_sync  <= in_meta;
         in_dly   <= in_sync;
         edge_cap <= edge_cap_n;
         irq      <= |(edge_cap & irq_mask);
         if (wr_mask) begin
            irq_mask <= writedata;
         end
      end
   end

   assign out_port = data_out;

   always_comb begin
      readdata = '0;
      unique case (address)
         3'd0:    readdata = data_out;
         3'd1:    readdata = in_sync;
         3'd2:    readdata = irq_mask;
         3'd3:    readdata = edge_cap;
`ifdef EASY_PIO_PULSE_EN
         3'd6:    readdata = WIDTH'(cnt);
`endif
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_easy_pio_gpio.sv
// tb_easy_pio_gpio: directed test of easy_pio_gpio.
// Pulse checks run when EASY_PIO_PULSE_EN is defined, reserved-6 checks otherwise.
module tb_easy_pio_gpio;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] in_port;
   logic [31:0] out_port;
   logic        irq;

   int total;
   int bad;

   easy_pio_gpio #(
      .WIDTH        (32),
      .RESET_VALUE  (32'h0000_00A5),
      .PULSE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write lands on the next posedge; returns 1 time unit after it.
   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic chk_rd(input string tag, input logic [2:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      address    = a;
      chipselect = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
      chk(tag, d, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;

      // reset overrides a same-cycle write
      step();
      bus_wr(3'd0, 32'h0000_0033);
      step();
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_out", out_port, 32'h0000_00A5);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk_rd("rst_data", 3'd0, 32'h0000_00A5);
      chk_rd("rst_in", 3'd1, 32'd0);
      chk_rd("rst_mask", 3'd2, 32'd0);
      chk_rd("rst_edge", 3'd3, 32'd0);
      chk_rd("rst_set", 3'd4, 32'd0);
      chk_rd("rst_clr", 3'd5, 32'd0);
      chk_rd("rst_pulse", 3'd6, 32'd0);
      chk_rd("rst_rsvd", 3'd7, 32'd0);

      // DATA / OUTSET / OUTCLEAR
      bus_wr(3'd0, 32'h0000_00F0);
      chk("data_f0", out_port, 32'h0000_00F0);
      bus_wr(3'd4, 32'h0000_000F);
      chk("set_0f", out_port, 32'h0000_00FF);
      bus_wr(3'd5, 32'h0000_0081);
      chk("clr_81", out_port, 32'h0000_007E);
      bus_wr(3'd7, 32'hFFFF_FFFF);
      chk("rsvd_wr", out_port, 32'h0000_007E);

      // edge capture and irq latency
      bus_wr(3'd2, 32'h0000_0001);
      chk_rd("mask_rd", 3'd2, 32'h0000_0001);
      @(negedge clk);
      in_port = 32'h0000_0001;
      step();
      step();
      chk_rd("in_2cyc", 3'd1, 32'h0000_0001);
      chk_rd("edge_e2", 3'd3, 32'd0);
      step();
      chk_rd("edge_e3", 3'd3, 32'h0000_0001);
      chk("irq_e3", {31'd0, irq}, 32'd0);
      step();
      chk("irq_e4", {31'd0, irq}, 32'd1);

      // W1C colliding with a new rising edge
      @(negedge clk);
      in_port = 32'h0;
      repeat (4) step();
      @(negedge clk);
      in_port = 32'h0000_0001;
      step();
      step();
      bus_wr(3'd3, 32'h0000_0001);
      chk_rd("w1c_race", 3'd3, 32'h0000_0001);
      step();
      chk("irq_race", {31'd0, irq}, 32'd1);

      // clean W1C
      bus_wr(3'd3, 32'h0000_0001);
      chk_rd("w1c_ok", 3'd3, 32'd0);
      chk("irq_clr0", {31'd0, irq}, 32'd1);
      step();
      chk("irq_clr1", {31'd0, irq}, 32'd0);

      // unmasked edge captured but no irq
      @(negedge clk);
      in_port = 32'h0000_0003;
      repeat (5) step();
      chk_rd("edge_b1", 3'd3, 32'h0000_0002);
      chk("irq_nomask", {31'd0, irq}, 32'd0);

`ifdef EASY_PIO_PULSE_EN
      // single pulse, 4 cycles
      bus_wr(3'd5, 32'hFFFF_FFFF);
      chk("pls_pre", out_port, 32'd0);
      bus_wr(3'd6, 32'h0000_0003);
      chk("pls_w", out_port, 32'h0000_0003);
      chk_rd("pls_cnt", 3'd6, 32'd4);
      for (int k = 1; k < 4; k++) begin
         step();
         chk($sformatf("pls_hi%0d", k), out_port, 32'h0000_0003);
      end
      step();
      chk("pls_end", out_port, 32'd0);
      chk_rd("pls_cnt0", 3'd6, 32'd0);

      // retrigger extends and merges masks
      bus_wr(3'd6, 32'h0000_0003);
      step();
      chk_rd("rtr_cnt", 3'd6, 32'd3);
      bus_wr(3'd6, 32'h0000_0004);
      chk("rtr_w2", out_port, 32'h0000_0007);
      chk_rd("rtr_cnt2", 3'd6, 32'd4);
      for (int k = 1; k < 4; k++) begin
         step();
         chk($sformatf("rtr_hi%0d", k), out_port, 32'h0000_0007);
      end
      step();
      chk("rtr_end", out_port, 32'd0);

      // DATA write on the expiry edge wins
      bus_wr(3'd6, 32'h0000_0002);
      repeat (3) step();
      bus_wr(3'd0, 32'h0000_0001);
      chk("exp_data", out_port, 32'h0000_0001);
      step();
      chk("exp_data2", out_port, 32'h0000_0001);
      chk_rd("exp_cnt", 3'd6, 32'd0);

      // reset mid-pulse aborts it
      bus_wr(3'd6, 32'h0000_0010);
      chk("mid_w", out_port, 32'h0000_0011);
      @(negedge clk);
      reset_n = 1'b0;
      step();
      chk("mid_rst", out_port, 32'h0000_00A5);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_rd("mid_cnt", 3'd6, 32'd0);
      bus_wr(3'd4, 32'h0000_0010);
      repeat (6) step();
      chk("mid_noclr", out_port, 32'h0000_00B5);
`else
      // address 6 is reserved in this build
      bus_wr(3'd6, 32'h0000_0003);
      chk("a6_out", out_port, 32'h0000_007E);
      chk_rd("a6_rd", 3'd6, 32'd0);
      repeat (6) step();
      chk("a6_hold", out_port, 32'h0000_007E);

      @(negedge clk);
      reset_n = 1'b0;
      step();
      chk("rst2_out", out_port, 32'h0000_00A5);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_rd("rst2_mask", 3'd2, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
